// File: rtl/scan_chain_pkg.sv
// scan_chain_pkg: shared defaults for the scan-chain responder slice.
package scan_chain_pkg;
  localparam int NUM_IO_DEF = 8;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-flop synchroniser with one extra stage for edge detection.
module sync_edge
  import scan_chain_pkg::*;
(
  input  logic clk,
  input  logic resetb,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall,
  output logic dly_out
);
  logic [SYNC_STAGES:0] pipe_q, pipe_d;
  always_comb pipe_d = {pipe_q[SYNC_STAGES-1:0], async_in};
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) pipe_q <= '0;
    else pipe_q <= pipe_d;
  assign sync_out = pipe_q[SYNC_STAGES-1];
  assign dly_out  = pipe_q[SYNC_STAGES];
  assign rise     = sync_out & ~dly_out;
  assign fall     = ~sync_out & dly_out;
endmodule

// File: rtl/scan_chain_responder.sv
// scan_chain_responder: design-side scan-chain slot; shifts, captures and latches
// chain data and forwards the chain signals retimed to the local clock.
module scan_chain_responder
  import scan_chain_pkg::*;
#(
  parameter int NUM_IO = NUM_IO_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              scan_clk_in,
  input  logic              scan_data_in,
  input  logic              scan_select_in,
  input  logic              latch_enable_in,
  output logic              scan_clk_out,
  output logic              scan_data_out,
  output logic              scan_select_out,
  output logic              latch_enable_out,
  output logic [NUM_IO-1:0] module_data_in,
  input  logic [NUM_IO-1:0] module_data_out,
  output logic [CNT_W-1:0]  shift_count
);
  logic sc_rise, sc_fall, sclk_s3, le_rise, le_s3;
  logic unused_sclk_s2, unused_le_s2, unused_le_fall;
  logic [1:0] data_sync_q, data_sync_d, sel_sync_q, sel_sync_d;
  logic sel_s3_q, sel_s3_d, sdo_q, sdo_d;
  logic [NUM_IO-1:0] shreg_q, shreg_d, mdi_q, mdi_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  sync_edge u_sclk (
    .clk(clk), .resetb(resetb), .async_in(scan_clk_in), .sync_out(unused_sclk_s2),
    .rise(sc_rise), .fall(sc_fall), .dly_out(sclk_s3)
  );

  sync_edge u_le (
    .clk(clk), .resetb(resetb), .async_in(latch_enable_in), .sync_out(unused_le_s2),
    .rise(le_rise), .fall(unused_le_fall), .dly_out(le_s3)
  );

  // Data and select share the scan clock's sync depth, so they line up with sc_rise.
  always_comb begin
    data_sync_d = {data_sync_q[0], scan_data_in};
    sel_sync_d  = {sel_sync_q[0], scan_select_in};
    sel_s3_d    = sel_sync_q[1];
    shreg_d     = !sc_rise ? shreg_q :
                  sel_sync_q[1] ? module_data_out : {shreg_q[NUM_IO-2:0], data_sync_q[1]};
    cnt_d       = !sc_rise ? cnt_q : sel_sync_q[1] ? '0 : &cnt_q ? cnt_q : cnt_q + 1'b1;
    sdo_d       = sc_fall ? shreg_q[NUM_IO-1] : sdo_q;
    mdi_d       = le_rise ? shreg_q : mdi_q;
  end

  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      data_sync_q <= '0;
      sel_sync_q  <= '0;
      sel_s3_q    <= 1'b0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      sdo_q       <= 1'b0;
      mdi_q       <= '0;
    end else begin
      data_sync_q <= data_sync_d;
      sel_sync_q  <= sel_sync_d;
      sel_s3_q    <= sel_s3_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      sdo_q       <= sdo_d;
      mdi_q       <= mdi_d;
    end

  assign scan_clk_out     = sclk_s3;
  assign latch_enable_out = le_s3;
  assign scan_select_out  = sel_s3_q;
  assign scan_data_out    = sdo_q;
  assign module_data_in   = mdi_q;
  assign shift_count      = cnt_q;
endmodule

// File: tb/tb_scan_chain_responder.sv
// tb_scan_chain_responder: random and directed scan traffic against an instantaneous
// pin-level model whose outputs the DUT must reproduce two clk edges later.
module tb_scan_chain_responder;
  logic clk = 1'b0;
  logic resetb = 1'b0;
  logic sclk = 1'b0, sdi = 1'b0, sel = 1'b0, le = 1'b0;
  logic [7:0] mdo = 8'h00, b_mdo = 8'h00;
  logic a_sclk_o, a_sdo, a_sel_o, a_le_o, b_sclk_o, b_sdo, b_sel_o, b_le_o;
  logic [7:0] a_mdi, b_mdi;
  logic [15:0] a_cnt, b_cnt;
  int errors = 0, checks = 0;
  logic last_sdo;

  always #5 clk = ~clk;

  scan_chain_responder u_a (
    .clk(clk), .resetb(resetb), .scan_clk_in(sclk), .scan_data_in(sdi),
    .scan_select_in(sel), .latch_enable_in(le), .scan_clk_out(a_sclk_o),
    .scan_data_out(a_sdo), .scan_select_out(a_sel_o), .latch_enable_out(a_le_o),
    .module_data_in(a_mdi), .module_data_out(mdo), .shift_count(a_cnt)
  );

  scan_chain_responder u_b (
    .clk(clk), .resetb(resetb), .scan_clk_in(a_sclk_o), .scan_data_in(a_sdo),
    .scan_select_in(a_sel_o), .latch_enable_in(a_le_o), .scan_clk_out(b_sclk_o),
    .scan_data_out(b_sdo), .scan_select_out(b_sel_o), .latch_enable_out(b_le_o),
    .module_data_in(b_mdi), .module_data_out(b_mdo), .shift_count(b_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic sclk, sdo, sel, le;
    logic [7:0] mdi, sh;
    logic [15:0] cnt;
  } st_t;

  st_t cur, nxt, h [3];
  logic p_sclk, p_le;

  // Model reacts to the pins at the very edge that first samples them.
  always @(posedge clk) begin
    if (!resetb) begin
      cur = '{default: 0};
      p_sclk = 1'b0;
      p_le = 1'b0;
      for (int i = 0; i < 3; i++) h[i] = cur;
    end else begin
      nxt = cur;
      if (le && !p_le) nxt.mdi = cur.sh;
      if (!sclk && p_sclk) nxt.sdo = cur.sh[7];
      if (sclk && !p_sclk) begin
        if (sel) begin
          nxt.sh = mdo;
          nxt.cnt = 16'h0;
        end else begin
          nxt.sh = {cur.sh[6:0], sdi};
          nxt.cnt = (cur.cnt == 16'hFFFF) ? cur.cnt : cur.cnt + 16'd1;
        end
      end
      nxt.sclk = sclk;
      nxt.sel = sel;
      nxt.le = le;
      cur = nxt;
      p_sclk = sclk;
      p_le = le;
      h[2] = h[1];
      h[1] = h[0];
      h[0] = cur;
    end
  end

  always @(negedge clk) begin
    st_t e;
    e = resetb ? h[2] : '{default: 0};
    chk("scan_clk_out", a_sclk_o, e.sclk);
    chk("scan_data_out", a_sdo, e.sdo);
    chk("scan_select_out", a_sel_o, e.sel);
    chk("latch_enable_out", a_le_o, e.le);
    chk("module_data_in", a_mdi, e.mdi);
    chk("shift_count", a_cnt, e.cnt);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic scyc(input logic d, input logic s, input int hh);
    sclk = 1'b0;
    sdi = d;
    sel = s;
    tick(hh);
    last_sdo = a_sdo;
    sclk = 1'b1;
    tick(hh);
  endtask

  task automatic latch_pulse(input int w);
    le = 1'b1;
    tick(w);
    le = 1'b0;
    tick(w);
  endtask

  task automatic shift_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) scyc(v[i], 1'b0, 10);
  endtask

  initial begin
    int da, db;
    logic [7:0] sdo_seq;
    logic [15:0] word;
    // Reset with toggling inputs
    for (int i = 0; i < 20; i++) begin
      {sclk, sdi, sel, le} = 4'($urandom);
      mdo = 8'($urandom);
      tick(1);
    end
    {sclk, sdi, sel, le} = 4'b0;
    tick(2);
    chk("reset_mdi", a_mdi, 8'h00);
    chk("reset_sdo", a_sdo, 1'b0);
    resetb = 1'b1;
    tick(10);
    chk("post_reset_cnt", a_cnt, 16'h0);
    chk("post_reset_mdi", a_mdi, 8'h00);

    // Shift A5 and latch
    shift_byte(8'hA5);
    latch_pulse(5);
    chk("shift_mdi", a_mdi, 8'hA5);
    chk("shift_cnt", a_cnt, 16'd8);
    chk("model_shift_mdi", cur.mdi, 8'hA5);

    // Capture 3C then shift it out
    mdo = 8'h3C;
    scyc(1'b0, 1'b1, 10);
    chk("capture_cnt", a_cnt, 16'd0);
    for (int i = 7; i >= 0; i--) begin
      scyc(1'b0, 1'b0, 10);
      sdo_seq[i] = last_sdo;
    end
    chk("capture_sdo_seq", sdo_seq, 8'h3C);
    chk("capture_end_cnt", a_cnt, 16'd8);

    // Simultaneous latch and shift rise
    shift_byte(8'h0F);
    sclk = 1'b0;
    sdi = 1'b1;
    tick(10);
    sclk = 1'b1;
    le = 1'b1;
    tick(10);
    le = 1'b0;
    tick(5);
    chk("simul_mdi", a_mdi, 8'h0F);
    chk("model_simul_mdi", cur.mdi, 8'h0F);
    latch_pulse(5);
    chk("simul_after_mdi", a_mdi, 8'h1F);

    // Mid-operation reset
    for (int i = 0; i < 4; i++) scyc(i[0], 1'b0, 10);
    resetb = 1'b0;
    tick(2);
    chk("midreset_mdi", a_mdi, 8'h00);
    chk("midreset_cnt", a_cnt, 16'h0);
    sclk = 1'b0;
    tick(3);
    resetb = 1'b1;
    tick(6);
    shift_byte(8'hFF);
    latch_pulse(5);
    chk("midreset_ff_mdi", a_mdi, 8'hFF);
    chk("midreset_ff_cnt", a_cnt, 16'd8);

    // Two-slot chain
    word = 16'h1234;
    for (int i = 15; i >= 0; i--) scyc(word[i], 1'b0, 10);
    sclk = 1'b0;
    tick(10);
    latch_pulse(6);
    tick(4);
    chk("chain_a_mdi", a_mdi, 8'h34);
    chk("chain_b_mdi", b_mdi, 8'h12);
    da = 0;
    db = 0;
    sclk = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (a_sclk_o && da == 0) da = k;
      if (b_sclk_o && db == 0) db = k;
    end
    chk("fwd_delay_a", da, 3);
    chk("fwd_delay_b", db, 6);

    // Random traffic
    for (int n = 0; n < 150; n++) begin
      mdo = 8'($urandom);
      scyc(1'($urandom), ($urandom_range(0, 5) == 0), $urandom_range(4, 8));
      if ($urandom_range(0, 7) == 0) latch_pulse($urandom_range(4, 6));
    end
    sclk = 1'b0;
    tick(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/scan_chain_responder.md
# scan_chain_responder

Design-side end of the scan-chain protocol driven by the scan controller. One instance sits in front of each user design slot. It samples the asynchronous scan clock, select and latch lines, captures the design's outputs, shifts chain data through an internal register, and latches inputs into the design. It also forwards every chain signal to the next slot, retimed to the local clock.

## Interface
Parameters:
- NUM_IO, 8: width of the design's input and output buses and of the shift register.
- CNT_W, 16: width of the shift-edge debug counter.

Ports:
- clk  in  1  local clock; every flop uses its rising edge.
- resetb  in  1  asynchronous, active-low reset.
- scan_clk_in  in  1  scan clock from the previous slot or the controller. Asynchronous to clk.
- scan_data_in  in  1  serial chain data.
- scan_select_in  in  1  1 = capture design outputs on the scan clock rise; 0 = shift.
- latch_enable_in  in  1  rising edge copies the shift register into module_data_in.
- scan_clk_out  out  1  retimed scan clock to the next slot.
- scan_data_out  out  1  serial data to the next slot.
- scan_select_out  out  1  retimed select to the next slot.
- latch_enable_out  out  1  retimed latch enable to the next slot.
- module_data_in  out  NUM_IO  drives the user design's inputs.
- module_data_out  in  NUM_IO  user design's outputs; treated as stable while being captured.
- shift_count  out  CNT_W  number of shift-mode scan clock rises since the last capture (debug).

## Operation
- Synchronisers: a 2-flop synchroniser on each of the four chain inputs gives the *_s2 signals. A third flop on the scan clock and on the latch enable gives *_s3.
  - sc_rise = sclk_s2 & ~sclk_s3
  - sc_fall = ~sclk_s2 & sclk_s3
  - le_rise = le_s2 & ~le_s3
- On sc_rise:
  - if sel_s2 = 1: shreg <= module_data_out and shift_count <= 0.
  - otherwise: shreg <= {shreg[NUM_IO-2:0], data_s2} and shift_count increments, saturating at all-ones.
- On sc_fall: the scan_data_out register loads shreg[NUM_IO-1]. Launching on the fall gives the next slot half a scan period of setup and hold.
- On le_rise: module_data_in <= shreg.
  - If le_rise and sc_rise occur in the same cycle, module_data_in takes the pre-update shreg. The shift or capture still happens.
- The debug counter has no effect on chain behaviour.
- Forwarding:
  - scan_clk_out = sclk_s3
  - latch_enable_out = le_s3
  - scan_select_out = a registered copy of sel_s2, aligned with sclk_s3
- Reset (asynchronous assert, synchronous-safe release): all synchroniser flops, shreg, module_data_in, shift_count and all four outputs go to 0.
  - A scan clock rise in progress during reset is lost. After release, the first edge is detected only once sclk_s2 differs from sclk_s3.

## Timing
- scan_clk_in edge to sc_rise/sc_fall: 2 clk cycles.
- sc_rise to updated shreg: +1 cycle, so 3 cycles from the pin.
- scan_clk_in fall to scan_data_out change: 3 cycles.
- latch_enable_in rise to module_data_in update: 3 cycles.
- scan_clk_in to scan_clk_out: 3 cycles. Both edges are delayed equally.
- Requirements on the source:
  - Scan clock high and low phases ≥ 4 clk cycles each.
  - scan_data_in and scan_select_in stable from 3 cycles before to 3 cycles after each scan clock rise.
  - latch_enable_in high and low phases ≥ 4 cycles each.
- Through an N-slot chain, scan_clk_out lags the controller by 3·N cycles. Data and select lag equally, so alignment is preserved.

## Structure
- Package scan_chain_pkg holds:
  - NUM_IO default
  - SYNC_STAGES = 2
  - CNT_W default
- Sub-module sync_edge: synchroniser plus edge detect. Ports: clk, resetb, async_in, sync_out, rise, fall, dly_out.
  - Instantiated for scan clock and latch enable.
  - Data and select use plain 2-flop synchronisers inside the top module.
- Top module: shreg, output register, latch register, counter, select alignment flop.

## Test plan
- Reset: hold resetb = 0 with inputs toggling -> all outputs 0. No edge is detected until a fresh scan clock transition after release.
- Shift: shift 8'hA5 MSB-first with select = 0, scan clock at 10 clk per half-period, then pulse latch -> module_data_in = 8'hA5, shift_count = 8.
- Capture: module_data_out = 8'h3C, one rise with select = 1, then 8 shift clocks -> scan_data_out emits 0,0,1,1,1,1,0,0 on successive falls; shift_count is 0 after the capture and 8 at the end.
- Pass-through chain: two instances in series, shift 16 bits 16'h1234 -> first instance latches 8'h34, second latches 8'h12. Forwarded clock delay is 3 cycles per instance.
- Simultaneous events: le_rise and sc_rise in the same cycle with shreg = 8'h0F and scan_data_in = 1 -> module_data_in = 8'h0F, then shreg = 8'h1F.
- Mid-operation reset: assert resetb after 4 of 8 shifts, release, shift 8'hFF and latch -> module_data_in = 8'hFF, shift_count = 8.
